// File: rtl/sm4_block_engine.sv
// Iterative SM4 engine: 32-cycle key expansion into a round-key file, then
// one round per clock for encrypt/decrypt, sharing four S-boxes between both.

module riscv_crypto_sm4_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign out_byte = SBOX[in_byte];
endmodule

module sm4_block_engine #(
    parameter bit RK_ZEROIZE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         key_zero,
    output logic         key_ok,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [127:0] din,
    input  logic         din_dec,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [127:0] dout,
    output logic         busy
);
    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, HOLD} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] kwin    [4];
    logic [31:0] xwin    [4];
    logic [31:0] rk_file [32];
    logic        dec;
    logic [31:0] rk_cur;
    logic [31:0] mix;
    logic [31:0] tau_out;
    logic [31:0] knew;
    logic [31:0] xnew;

    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // CK byte j of round i is ((4i+j)*7) mod 256
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [9:0]  idx;
        logic [9:0]  prod;
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            idx  = {3'b000, i, 2'b00} + 10'(j);
            prod = idx * 10'd7;
            w[31-8*j -: 8] = prod[7:0];
        end
        return w;
    endfunction

    assign din_ready = (state == READY) && key_ok;
    assign key_ready = ((state == IDLE) || (state == READY)) && !(din_valid && din_ready) && !key_zero;
    assign busy      = (state == KEXP) || (state == RUN);
    assign rk_cur    = rk_file[dec ? ~cnt : cnt];

    always_comb begin
        mix = xwin[1] ^ xwin[2] ^ xwin[3] ^ rk_cur;
        if (state == KEXP)
            mix = kwin[1] ^ kwin[2] ^ kwin[3] ^ ck_word(cnt);
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        riscv_crypto_sm4_sbox u_sbox (
            .in_byte  (mix[8*g +: 8]),
            .out_byte (tau_out[8*g +: 8])
        );
    end

    assign knew = kwin[0] ^ tau_out ^ rol(tau_out, 13) ^ rol(tau_out, 23);
    assign xnew = xwin[0] ^ tau_out ^ rol(tau_out, 2) ^ rol(tau_out, 10)
                ^ rol(tau_out, 18) ^ rol(tau_out, 24);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            key_ok     <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            dec        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                kwin[i] <= '0;
                xwin[i] <= '0;
            end
            for (int i = 0; i < 32; i++)
                rk_file[i] <= '0;
        end else if (key_zero) begin
            state      <= IDLE;
            cnt        <= '0;
            key_ok     <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            if (RK_ZEROIZE) begin
                for (int i = 0; i < 32; i++)
                    rk_file[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, READY: begin
                    if (din_valid && din_ready) begin
                        for (int i = 0; i < 4; i++)
                            xwin[i] <= din[127-32*i -: 32];
                        dec   <= din_dec;
                        cnt   <= '0;
                        state <= RUN;
                    end else if (key_valid && key_ready) begin
                        for (int i = 0; i < 4; i++)
                            kwin[i] <= key_in[127-32*i -: 32] ^ FK[127-32*i -: 32];
                        key_ok <= 1'b0;
                        cnt    <= '0;
                        state  <= KEXP;
                    end
                end
                KEXP: begin
                    rk_file[cnt] <= knew;
                    kwin[0] <= kwin[1];
                    kwin[1] <= kwin[2];
                    kwin[2] <= kwin[3];
                    kwin[3] <= knew;
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        key_ok <= 1'b1;
                        state  <= READY;
                    end
                end
                RUN: begin
                    xwin[0] <= xwin[1];
                    xwin[1] <= xwin[2];
                    xwin[2] <= xwin[3];
                    xwin[3] <= xnew;
                    cnt     <= cnt + 5'd1;
                    // Output is the last four words in reverse order
                    if (cnt == 5'd31) begin
                        dout       <= {xnew, xwin[3], xwin[2], xwin[1]};
                        dout_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sm4_block_engine.sv
// Scoreboard bench for sm4_block_engine: known-answer vectors, random traffic
// against an array-based SM4 model, stall, key_zero abort and async reset.

module tb_sm4_block_engine;
    localparam logic [127:0] FK     = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [127:0] KAT_K  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [0:255][7:0] SB = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         key_zero = 1'b0;
    logic         key_ok;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] din = '0;
    logic         din_dec = 1'b0;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic [127:0] dout;
    logic         busy;

    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];
    logic [31:0]  m_rk[32];

    sm4_block_engine #(.RK_ZEROIZE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .key_zero(key_zero), .key_ok(key_ok),
        .din_valid(din_valid), .din_ready(din_ready), .din(din), .din_dec(din_dec),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
    endfunction

    function automatic void model_expand(input logic [127:0] mk);
        logic [31:0] k[36];
        logic [31:0] ck;
        logic [31:0] b;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
            m_rk[i] = k[i+4];
        end
    endfunction

    function automatic logic [127:0] model_crypt(input logic [127:0] blk, input bit dec);
        logic [31:0] x[36];
        logic [31:0] b;
        for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ m_rk[dec ? 31 - i : i]);
            x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dout got=%h required=no_output", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_key(input logic [127:0] k);
        int n;
        key_in = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        model_expand(k);
        n = 0;
        while (!key_ok && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("key_ok_latency", 128'(n), 128'd32);
    endtask

    task automatic send_block(input logic [127:0] blk, input bit dec, input logic [127:0] expv);
        int n;
        din = blk;
        din_dec = dec;
        din_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        din_valid = 1'b0;
        n = 0;
        while (!dout_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("dout_latency", 128'(n), 128'd32);
        if (dout_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [127:0] k, blk;
        bit d;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_ok", 128'(key_ok), 128'd0);
        check("rst_dout_valid", 128'(dout_valid), 128'd0);
        check("rst_dout", dout, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_key_ready", 128'(key_ready), 128'd1);
        check("idle_din_ready", 128'(din_ready), 128'd0);

        // known-answer key schedule and blocks
        load_key(KAT_K);
        check("rk0", 128'(dut.rk_file[0]), 128'hf12186f9);
        check("rk31", 128'(dut.rk_file[31]), 128'h9124a012);
        send_block(KAT_PT, 1'b0, KAT_CT);
        send_block(KAT_CT, 1'b1, KAT_PT);

        // stalled consumer
        dout_ready = 1'b0;
        send_block(KAT_PT, 1'b0, KAT_CT);
        for (int c = 0; c < 10; c++) begin
            check("hold_dout", dout, KAT_CT);
            check("hold_valid", 128'(dout_valid), 128'd1);
            check("hold_din_ready", 128'(din_ready), 128'd0);
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_valid", 128'(dout_valid), 128'd0);
        check("post_hs_din_ready", 128'(din_ready), 128'd1);
        check("post_hs_dout_kept", dout, KAT_CT);

        // key_zero during round 15
        din = KAT_PT;
        din_dec = 1'b0;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_zero_busy", 128'(busy), 128'd1);
        key_zero = 1'b1;
        key_valid = 1'b1;
        key_in = KAT_K;
        @(posedge clk); #1;
        key_zero = 1'b0;
        key_valid = 1'b0;
        check("zero_key_ok", 128'(key_ok), 128'd0);
        check("zero_din_ready", 128'(din_ready), 128'd0);
        check("zero_busy", 128'(busy), 128'd0);
        check("zero_rk0", 128'(dut.rk_file[0]), 128'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (dout_valid) check("zero_no_output", 128'(dout_valid), 128'd0);
        end
        check("zero_still_idle", 128'(key_ready), 128'd1);
        load_key(KAT_K);
        send_block(KAT_PT, 1'b0, KAT_CT);

        // random traffic against the model
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            load_key(k);
            for (int b = 0; b < 4; b++) begin
                blk = {$urandom, $urandom, $urandom, $urandom};
                d = 1'($urandom_range(0, 1));
                send_block(blk, d, model_crypt(blk, d));
            end
        end

        // asynchronous reset in the middle of key expansion
        key_in = KAT_K;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_key_ok", 128'(key_ok), 128'd0);
        check("arst_dout_valid", 128'(dout_valid), 128'd0);
        check("arst_dout", dout, 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_din_ready", 128'(din_ready), 128'd0);
        check("arst_rk5", 128'(dut.rk_file[5]), 128'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_rst_key_ready", 128'(key_ready), 128'd1);
        check("after_rst_busy", 128'(busy), 128'd0);
        load_key(KAT_K);
        send_block(KAT_CT, 1'b1, KAT_PT);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sm4_block_engine.md
Name: sm4_block_engine

Overview:
- Iterative SM4 block cipher engine sitting beside the scalar crypto FU as a standalone 128-bit accelerator.
- Expands a 128-bit master key into 32 round keys held in an internal file, then encrypts or decrypts 128-bit blocks at one round per clock.
- Decryption is the inverse direction of the same datapath: it reads the round keys in reverse order.
- Uses four instances of riscv_crypto_sm4_sbox, shared between key expansion and data rounds.

Parameters:
- RK_ZEROIZE, 1: when 1, key_zero clears the round-key file; when 0, key_zero only drops key_ok.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  master key offered
- key_ready  out  1  engine accepts a key this cycle
- key_in  in  128  master key MK, MK0 in [127:96]
- key_zero  in  1  invalidate the loaded key
- key_ok  out  1  round keys valid
- din_valid  in  1  input block offered
- din_ready  out  1  engine accepts a block this cycle
- din  in  128  block X0..X3, X0 in [127:96]
- din_dec  in  1  1 = decrypt, 0 = encrypt; sampled with din
- dout_valid  out  1  result available
- dout_ready  in  1  consumer accepts the result
- dout  out  128  result {X35,X34,X33,X32}
- busy  out  1  state is KEXP or RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE, round counter 0.
  - key_ok=0, dout_valid=0, dout=0, busy=0.
  - Round-key file cleared to 0.
  - Any operation in flight is abandoned and produces no output.
- States: IDLE, KEXP, READY, RUN, HOLD.
- Ready signals:
  - key_ready=1 only in IDLE and READY.
  - din_ready=1 only in READY with key_ok=1.
- IDLE, READY: on key_valid&key_ready:
  - Load K0..3 = MK ^ FK, with FK = a3b1bac6 56aa3350 677d9197 b27022dc.
  - key_ok<=0, counter<=0, go to KEXP.
- KEXP, per cycle i = 0..31:
  - rk[i] = K(i+4) = Ki ^ L'(tau(K(i+1)^K(i+2)^K(i+3)^CKi)).
  - L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - CKi byte j = ((4i+j)*7) mod 256, generated combinationally from the counter.
  - Shift the K window by one word.
  - After i=31: key_ok<=1, go to READY. Expansion takes exactly 32 cycles after the accept edge.
- READY: on din_valid&din_ready:
  - Latch din into the X window and latch din_dec.
  - counter<=0, go to RUN.
  - A simultaneous key_valid is ignored (key_ready=0 is forced when din_valid&din_ready).
- RUN, per cycle i = 0..31:
  - X(i+4) = Xi ^ L(tau(X(i+1)^X(i+2)^X(i+3)^rk[j])).
  - j = i for encrypt, j = 31-i for decrypt.
  - L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
  - After i=31: dout<={X35,X34,X33,X32}, dout_valid<=1, go to HOLD.
  - dout_valid rises 32 cycles after the accept edge.
- HOLD:
  - dout and dout_valid stay stable until dout_valid&dout_ready, then dout_valid<=0 and go to READY.
  - dout keeps its last value after the handshake.
  - No new block is accepted in HOLD (no bypass).
- key_zero, highest priority:
  - Takes effect in any state: key_ok<=0, go to IDLE.
  - An in-progress RUN or KEXP is aborted with no output.
  - A pending HOLD result is dropped: dout_valid<=0, dout<=0.
  - rk file zeroed if RK_ZEROIZE=1.
  - If key_valid is high in the same cycle, key_zero wins and the key is not accepted.
- Reloading a key from READY overwrites the key; key_ok is 0 for the 32-cycle expansion.
- Counter: 5 bits; wraps 31->0 only at the state exit.
- All word rotations are 32-bit circular. tau applies the SM4 S-box bytewise via the 4 sbox instances.

Test Plan:
1. Key 0123456789abcdeffedcba9876543210, expand -> key_ok rises 32 cycles after accept; rk[0]=f12186f9, rk[31]=9124a012.
2. Encrypt din 0123456789abcdeffedcba9876543210 -> dout 681edf34d206965e86b3e94f536e4246, dout_valid 32 cycles after accept.
3. Decrypt din 681edf34d206965e86b3e94f536e4246 (din_dec=1) -> dout 0123456789abcdeffedcba9876543210.
4. dout_ready held 0 for 10 cycles -> dout stable, din_ready=0 throughout; then dout_ready=1 -> one-cycle handshake, back in READY.
5. Assert key_zero at RUN round 15 -> no dout_valid, key_ok=0, din_ready=0; a fresh key load then encrypt gives the scenario-2 result.
6. Drop rst_n mid-KEXP -> all outputs 0 immediately; after release the engine is IDLE with key_ready=1.
